dmem_hs: RTL and testbench

DMEM_HS -- requirements
Module: dmem_hs

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_hs_if.sv | 34 +++
 rtl/dmem_array.sv | 45 ++++
 rtl/dmem_hs.sv | 153 +++++++++++++++
 tb/tb_dmem_hs.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and constants for the handshaked data memory (dmem_hs).
//   dmem_state_e : control FSM states (IDLE, WAIT, RESP)
//   LAT_MIN/MAX  : legal request-to-response latency range
//   CNT_W        : width of the latency down-counter (holds up to LAT_MAX-2)
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 7;
   localparam int CNT_W   = 3;

endpackage

// File: rtl/dmem_hs_if.sv
// dmem_hs_if
// Request/response handshake bundle for dmem_hs.
//   req_valid/req_ready : request handshake (accept when both high)
//   req_we              : 1 = write, 0 = read
//   req_addr            : byte address (ADDR_W)
//   req_wdata/req_be    : write data and byte enables
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : read data and access-fault flag
// Modports: master (requester / response consumer), slave (memory).
interface dmem_hs_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_be;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_array.sv
// dmem_array
// Single-port byte-enabled word storage with synchronous write and
// registered read. Contents are never reset.
//   clk   : clock
//   en    : access strobe for this cycle
//   we    : 1 = write enabled bytes, 0 = read into rdata
//   idx   : word index
//   wdata : write data
//   be    : byte enables (one per byte of wdata)
//   rdata : registered read data, holds until the next read
module dmem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                clk,
   input  logic                en,
   input  logic                we,
   input  logic [IDX_W-1:0]    idx,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   rdata
);
   localparam int BYTES = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (en && !we) rdata_d = mem_q[idx];
   end

   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int b = 0; b < BYTES; b++) begin
            if (be[b]) mem_q[idx][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_hs.sv
// dmem_hs
// Handshaked data memory with fixed request-to-response latency LAT.
// One access is in flight at a time; a new request may be accepted in the
// same cycle the previous response is consumed.
//   clk   : clock
//   rst_n : synchronous active-low reset (array contents are kept)
//   bus   : dmem_hs_if slave modport (request and response channels)
// Misaligned or out-of-range accesses respond with rsp_err=1, rsp_rdata=0
// and leave the array untouched.
module dmem_hs
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int LAT    = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   dmem_hs_if.slave  bus
);
   localparam int BYTES = DATA_W / 8;
   localparam int SHIFT = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
   localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_INIT = (LAT > 1) ? CNT_W'(LAT - 2) : '0;
   localparam dmem_state_e       ACC_STATE = (LAT == 1) ? RESP : WAIT;

   if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
      $error("dmem_hs: LAT must be within 1..7");
   end
   if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_width
      $error("dmem_hs: DATA_W must be a non-zero multiple of 8");
   end

   dmem_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [BYTES-1:0]    be_q, be_d;
   logic                rsp_err_q, rsp_err_d;
   logic                rsp_rd_q, rsp_rd_d;

   logic                req_ready, rsp_valid, accept;
   logic                op_live, op_fire, op_we, fault;
   logic [ADDR_W-1:0]   op_addr, word_idx;
   logic [DATA_W-1:0]   op_wdata, arr_rdata;
   logic [BYTES-1:0]    op_be;

   assign accept = bus.req_valid & req_ready;

   // With LAT=1 the array access happens on the accept edge itself, so it
   // must see the live request rather than the captured copy.
   assign op_live  = accept && (LAT == 1);
   assign op_fire  = op_live || (state_q == WAIT && cnt_q == '0);
   assign op_we    = op_live ? bus.req_we    : we_q;
   assign op_addr  = op_live ? bus.req_addr  : addr_q;
   assign op_wdata = op_live ? bus.req_wdata : wdata_q;
   assign op_be    = op_live ? bus.req_be    : be_q;

   assign word_idx = op_addr >> SHIFT;
   assign fault    = ((op_addr & OFF_MASK) != '0) || ({1'b0, word_idx} >= DEPTH_X);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rsp_err_q <= 1'b0;
         rsp_rd_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rsp_err_q <= rsp_err_d;
         rsp_rd_q  <= rsp_rd_d;
      end
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
   end

   // Next-state, counter and captured-request logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = ACC_STATE;
         WAIT:    if (cnt_q == '0) state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = accept ? ACC_STATE : IDLE;
         default: state_d = IDLE;
      endcase

      cnt_d = cnt_q;
      if (accept) cnt_d = CNT_INIT;
      else if (state_q == WAIT && cnt_q != '0) cnt_d = cnt_q - 1'b1;

      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      if (accept) begin
         we_d    = bus.req_we;
         addr_d  = bus.req_addr;
         wdata_d = bus.req_wdata;
         be_d    = bus.req_be;
      end

      // Response attributes are fixed on the edge entering RESP and then held.
      rsp_err_d = rsp_err_q;
      rsp_rd_d  = rsp_rd_q;
      if (op_fire) begin
         rsp_err_d = fault;
         rsp_rd_d  = ~fault & ~op_we;
      end
   end

   // Output logic
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: req_ready = rst_n;
         RESP: begin
            req_ready = rst_n & bus.rsp_ready;
            rsp_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Gating with rst_n drops a write whose commit edge coincides with reset.
   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (op_fire & ~fault & rst_n),
      .we    (op_we),
      .idx   (word_idx[IDX_W-1:0]),
      .wdata (op_wdata),
      .be    (op_be),
      .rdata (arr_rdata)
   );

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rd_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_hs.sv
// tb_dmem_hs
// Three dmem_hs instances (LAT = 2, 1, 7) share clk/rst_n. A negedge
// reference model tracks each instance's outstanding access by cycle count
// and predicts req_ready, rsp_valid, rsp_rdata and rsp_err.
module tb_dmem_hs;

   localparam int N = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid_a [N];
   logic        req_we_a    [N];
   logic [31:0] req_addr_a  [N];
   logic [31:0] req_wdata_a [N];
   logic [3:0]  req_be_a    [N];
   logic        rsp_ready_a [N];
   wire         req_ready_w [N];
   wire         rsp_valid_w [N];
   wire [31:0]  rsp_rdata_w [N];
   wire         rsp_err_w   [N];

   for (genvar g = 0; g < N; g++) begin : g_inst
      localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
      dmem_hs_if #(.ADDR_W(32), .DATA_W(32)) bus ();
      assign bus.req_valid = req_valid_a[g];
      assign bus.req_we    = req_we_a[g];
      assign bus.req_addr  = req_addr_a[g];
      assign bus.req_wdata = req_wdata_a[g];
      assign bus.req_be    = req_be_a[g];
      assign bus.rsp_ready = rsp_ready_a[g];
      assign req_ready_w[g] = bus.req_ready;
      assign rsp_valid_w[g] = bus.rsp_valid;
      assign rsp_rdata_w[g] = bus.rsp_rdata;
      assign rsp_err_w[g]   = bus.rsp_err;
      dmem_hs #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .LAT(L)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus.slave)
      );
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s inst%0d t=%0t: got %h expected %h", nm, i, $time, act, exp);
      end
   endtask

   function automatic int lat_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 7);
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] mmem   [N][1024];
   bit          mknown [N][1024];
   bit          pend [N];
   bit          resolved [N];
   int          due [N];
   logic        p_we [N];
   logic [31:0] p_addr [N];
   logic [31:0] p_wdata [N];
   logic [3:0]  p_be [N];
   logic [31:0] e_rdata [N];
   logic        e_err [N];
   bit          e_known [N];
   int          cyc = 0;

   initial begin
      for (int i = 0; i < N; i++) begin
         pend[i] = 0;
         for (int w = 0; w < 1024; w++) mknown[i][w] = 0;
      end
   end

   // Effect of an access: misaligned or beyond 1024 words faults; writes
   // merge enabled bytes; reads return the current word.
   task automatic resolve(input int i);
      logic [31:0] a;
      int          w;
      a = p_addr[i];
      resolved[i] = 1;
      e_known[i] = 1;
      e_rdata[i] = 32'h0;
      e_err[i] = 1'b0;
      if ((a % 4) != 0 || (a / 4) >= 1024) begin
         e_err[i] = 1'b1;
      end else begin
         w = int'(a / 4);
         if (p_we[i]) begin
            for (int b = 0; b < 4; b++)
               if (p_be[i][b]) mmem[i][w][b*8 +: 8] = p_wdata[i][b*8 +: 8];
            if (p_be[i] == 4'hF) mknown[i][w] = 1;
         end else begin
            e_rdata[i] = mmem[i][w];
            e_known[i] = mknown[i][w];
         end
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin : per_inst
         bit ev;
         bit er;
         if (pend[i] && !resolved[i] && cyc >= due[i]) resolve(i);
         ev = pend[i] && (cyc >= due[i]);
         er = rst_n && (!pend[i] || (ev && rsp_ready_a[i]));
         check("rsp_valid", i, {31'b0, rsp_valid_w[i]}, {31'b0, ev});
         check("req_ready", i, {31'b0, req_ready_w[i]}, {31'b0, er});
         if (ev) begin
            check("rsp_err", i, {31'b0, rsp_err_w[i]}, {31'b0, e_err[i]});
            if (e_known[i]) check("rsp_rdata", i, rsp_rdata_w[i], e_rdata[i]);
         end
         if (!rst_n) begin
            pend[i] = 0;
         end else begin
            if (ev && rsp_ready_a[i]) pend[i] = 0;
            if (req_valid_a[i] && er) begin
               pend[i]     = 1;
               resolved[i] = 0;
               due[i]      = cyc + lat_of(i);
               p_we[i]     = req_we_a[i];
               p_addr[i]   = req_addr_a[i];
               p_wdata[i]  = req_wdata_a[i];
               p_be[i]     = req_be_a[i];
            end
         end
      end
      cyc++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_req(input int i, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output int n, output logic [31:0] rd, output logic err);
      bit ok;
      @(posedge clk); #1;
      req_valid_a[i] = 1'b1; req_we_a[i] = we; req_addr_a[i] = addr;
      req_wdata_a[i] = wdata; req_be_a[i] = be; rsp_ready_a[i] = 1'b1;
      ok = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req_ready_w[i]) begin ok = 1; break; end
      end
      check("accept_seen", i, {31'b0, ok}, 32'd1);
      @(posedge clk); #1;
      req_valid_a[i] = 1'b0;
      n = 0; ok = 0; rd = 'x; err = 1'bx;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         n++;
         if (rsp_valid_w[i]) begin ok = 1; rd = rsp_rdata_w[i]; err = rsp_err_w[i]; break; end
      end
      check("rsp_seen", i, {31'b0, ok}, 32'd1);
   endtask

   function automatic logic [31:0] rnd_addr();
      int k;
      logic [31:0] w;
      k = $urandom_range(0, 9);
      w = 32'($urandom_range(0, 7)) * 4;
      if (k < 7) return w;
      if (k == 7) return w + 32'($urandom_range(1, 3));
      if (k == 8) return 32'h1000 + w;
      return 32'hFFFF_FFF0;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int          n;
      logic [31:0] rd;
      logic        er;
      for (int i = 0; i < N; i++) begin
         req_valid_a[i] = 0; req_we_a[i] = 0; req_addr_a[i] = 0;
         req_wdata_a[i] = 0; req_be_a[i] = 0; rsp_ready_a[i] = 1;
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("ready_in_reset", 0, {31'b0, req_ready_w[0]}, 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_rst", 0, {31'b0, req_ready_w[0]}, 32'd1);
      check("valid_after_rst", 0, {31'b0, rsp_valid_w[0]}, 32'd0);

      // Full write then read, LAT=2
      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, n, rd, er);
      check("wr_lat", 0, n, 2);
      check("wr_rdata", 0, rd, 32'h0);
      check("wr_err", 0, {31'b0, er}, 32'd0);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, n, rd, er);
      check("rd_lat", 0, n, 2);
      check("rd_data", 0, rd, 32'hDEADBEEF);
      check("rd_err", 0, {31'b0, er}, 32'd0);

      // Single-byte write merge
      do_req(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, n, rd, er);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, n, rd, er);
      check("merge_data", 0, rd, 32'hDEADBEAA);

      // be=0 write is a no-op that still responds
      do_req(0, 1'b1, 32'h10, 32'h55555555, 4'h0, n, rd, er);
      check("be0_err", 0, {31'b0, er}, 32'd0);

      // Faults
      do_req(0, 1'b0, 32'h12, 32'h0, 4'h0, n, rd, er);
      check("misal_err", 0, {31'b0, er}, 32'd1);
      check("misal_data", 0, rd, 32'h0);
      do_req(0, 1'b0, 32'h1000, 32'h0, 4'h0, n, rd, er);
      check("oor_err", 0, {31'b0, er}, 32'd1);
      check("oor_data", 0, rd, 32'h0);
      do_req(0, 1'b1, 32'h13, 32'h11111111, 4'hF, n, rd, er);
      check("misal_wr_err", 0, {31'b0, er}, 32'd1);
      do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, n, rd, er);
      check("after_fault", 0, rd, 32'hDEADBEAA);

      // Response back-pressure, then same-cycle accept
      @(posedge clk); #1;
      req_valid_a[0] = 1; req_we_a[0] = 0; req_addr_a[0] = 32'h10; rsp_ready_a[0] = 0;
      @(negedge clk);
      check("stall_acc", 0, {31'b0, req_ready_w[0]}, 32'd1);
      @(posedge clk); #1; req_valid_a[0] = 0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_valid", 0, {31'b0, rsp_valid_w[0]}, 32'd1);
         check("stall_data", 0, rsp_rdata_w[0], 32'hDEADBEAA);
         check("stall_ready", 0, {31'b0, req_ready_w[0]}, 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready_a[0] = 1; req_valid_a[0] = 1; req_addr_a[0] = 32'h10;
      @(negedge clk);
      check("same_cyc_acc", 0, {31'b0, req_ready_w[0]}, 32'd1);
      @(posedge clk); #1; req_valid_a[0] = 0;
      @(negedge clk);
      check("b2b_wait", 0, {31'b0, rsp_valid_w[0]}, 32'd0);
      @(negedge clk);
      check("b2b_valid", 0, {31'b0, rsp_valid_w[0]}, 32'd1);
      check("b2b_data", 0, rsp_rdata_w[0], 32'hDEADBEAA);

      // Reset during WAIT aborts a pending write
      do_req(0, 1'b1, 32'h20, 32'h0, 4'hF, n, rd, er);
      @(posedge clk); #1;
      req_valid_a[0] = 1; req_we_a[0] = 1; req_addr_a[0] = 32'h20;
      req_wdata_a[0] = 32'h12345678; req_be_a[0] = 4'hF;
      @(negedge clk);
      check("rst_acc", 0, {31'b0, req_ready_w[0]}, 32'd1);
      @(posedge clk); #1; rst_n = 0; req_valid_a[0] = 0;
      @(posedge clk); #1;
      @(posedge clk); #1; rst_n = 1;
      @(negedge clk);
      check("rst_no_valid", 0, {31'b0, rsp_valid_w[0]}, 32'd0);
      check("rst_idle_ready", 0, {31'b0, req_ready_w[0]}, 32'd1);
      do_req(0, 1'b0, 32'h20, 32'h0, 4'h0, n, rd, er);
      check("rst_no_commit", 0, rd, 32'h0);

      // LAT=1 and LAT=7 latency pins
      do_req(1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, n, rd, er);
      check("lat1_wr", 1, n, 1);
      do_req(1, 1'b0, 32'h8, 32'h0, 4'h0, n, rd, er);
      check("lat1_rd", 1, n, 1);
      check("lat1_data", 1, rd, 32'hCAFEF00D);
      do_req(2, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, n, rd, er);
      check("lat7_wr", 2, n, 7);
      do_req(2, 1'b0, 32'h4, 32'h0, 4'h0, n, rd, er);
      check("lat7_rd", 2, n, 7);
      check("lat7_data", 2, rd, 32'h0BADF00D);

      // Back-to-back reads on LAT=1 and LAT=7 (model checks timing)
      @(posedge clk); #1;
      for (int c = 0; c < 40; c++) begin
         for (int i = 1; i < N; i++) begin
            req_valid_a[i] = 1; req_we_a[i] = 0; rsp_ready_a[i] = 1;
            req_addr_a[i] = 32'($urandom_range(0, 7)) * 4;
         end
         @(posedge clk); #1;
      end

      // Randomized traffic on all instances, with one reset mid-way
      for (int c = 0; c < 1500; c++) begin
         rst_n = !(c == 700 || c == 701);
         for (int i = 0; i < N; i++) begin
            req_valid_a[i] = ($urandom_range(0, 2) != 0);
            req_we_a[i]    = $urandom_range(0, 1);
            req_addr_a[i]  = rnd_addr();
            req_wdata_a[i] = $urandom;
            req_be_a[i]    = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            rsp_ready_a[i] = ($urandom_range(0, 3) != 0);
         end
         @(posedge clk); #1;
      end

      for (int i = 0; i < N; i++) begin
         req_valid_a[i] = 0; rsp_ready_a[i] = 1;
      end
      repeat (10) @(posedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
